// File: rtl/noc_packet_sink_checker.sv
// rtl/noc_packet_sink_checker.sv - NoC local-port ejection sink that checks packet format and counts good/bad packets
`ifndef NOC_PARAMETERS_DEFINED
`define NOC_PARAMETERS_DEFINED
`define Noc_Data_Width   32
`define Noc_ID_X_Width   4
`define Noc_ID_Y_Width   4
`define Noc_Point_H      32
`define Noc_Source_Point 24
`endif

module noc_packet_sink_checker #(
    parameter logic [`Noc_ID_X_Width-1:0] X_ID           = '0,
    parameter logic [`Noc_ID_Y_Width-1:0] Y_ID           = '0,
    parameter int                         EXP_DATA_FLITS = 1,
    parameter logic [`Noc_Data_Width-1:0] DATA_PATTERN   = '1,
    parameter int                         STALL_PERIOD   = 0
) (
    input  logic                          noc_clk,
    input  logic                          noc_rst,
    input  logic                          receive_valid,
    output logic                          receive_ready,
    input  logic [`Noc_Data_Width-1:0]    receive_flit,
    input  logic                          receive_is_header,
    input  logic                          receive_is_tail,
    output logic                          pkt_done,
    output logic                          pkt_ok,
    output logic [`Noc_ID_X_Width-1:0]    last_src_x,
    output logic [`Noc_ID_Y_Width-1:0]    last_src_y,
    output logic [15:0]                   pkt_count,
    output logic [15:0]                   err_count,
    output logic [5:0]                    err_flags
);
    localparam int          XW      = `Noc_ID_X_Width;
    localparam int          YW      = `Noc_ID_Y_Width;
    localparam int          SRC_LO  = `Noc_Source_Point;
    localparam int          DST_LO  = `Noc_Source_Point - XW - YW;
    localparam logic [7:0]  EXP8    = EXP_DATA_FLITS[7:0];
    localparam logic [7:0]  P8      = STALL_PERIOD[7:0];
    localparam logic [7:0]  P_LAST  = P8 - 8'd1;
    localparam bit          STALLS  = (STALL_PERIOD != 0);

    typedef enum logic [1:0] {IDLE, PAYLOAD, EXPECT_TAIL} state_t;

    state_t          state;
    logic [7:0]      stall_cnt;
    logic [7:0]      stall_nxt;
    logic [7:0]      data_cnt;
    logic [XW-1:0]   src_x;
    logic [YW-1:0]   src_y;
    logic            bad;

    logic            accept;
    logic [XW-1:0]   flit_src_x;
    logic [YW-1:0]   flit_src_y;
    logic            dest_bad;
    logic            data_ok;
    logic            src_mismatch;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign accept       = receive_valid && receive_ready;
    assign flit_src_x   = receive_flit[`Noc_Point_H-1 -: XW];
    assign flit_src_y   = receive_flit[SRC_LO +: YW];
    assign dest_bad     = (receive_flit[DST_LO +: XW+YW] != {X_ID, Y_ID});
    assign data_ok      = (receive_flit == DATA_PATTERN);
    assign src_mismatch = (flit_src_x != src_x) || (flit_src_y != src_y);
    assign stall_nxt    = (stall_cnt == P_LAST) ? 8'd0 : stall_cnt + 8'd1;

    // Ready is registered against the next counter value so it drops in the cycle the counter sits at P-1
    always_ff @(posedge noc_clk or posedge noc_rst) begin
        if (noc_rst) begin
            stall_cnt     <= 8'd0;
            receive_ready <= !STALLS;
        end else if (!STALLS) begin
            receive_ready <= 1'b1;
        end else begin
            stall_cnt     <= stall_nxt;
            receive_ready <= (stall_nxt != P_LAST);
        end
    end

    always_ff @(posedge noc_clk or posedge noc_rst) begin
        if (noc_rst) begin
            state      <= IDLE;
            data_cnt   <= 8'd0;
            src_x      <= '0;
            src_y      <= '0;
            bad        <= 1'b0;
            pkt_done   <= 1'b0;
            pkt_ok     <= 1'b0;
            last_src_x <= '0;
            last_src_y <= '0;
            pkt_count  <= 16'd0;
            err_count  <= 16'd0;
            err_flags  <= 6'd0;
        end else begin
            pkt_done <= 1'b0;
            if (accept) begin
                if (receive_is_header && receive_is_tail) begin
                    err_flags[5] <= 1'b1;
                    err_count    <= sat_inc(err_count);
                end else if (receive_is_header) begin
                    // A header inside an open packet closes it as bad before starting the new one
                    if (state != IDLE) begin
                        err_flags[5] <= 1'b1;
                        pkt_done     <= 1'b1;
                        pkt_ok       <= 1'b0;
                        last_src_x   <= src_x;
                        last_src_y   <= src_y;
                        err_count    <= sat_inc(err_count);
                    end
                    src_x        <= flit_src_x;
                    src_y        <= flit_src_y;
                    bad          <= dest_bad;
                    err_flags[1] <= err_flags[1] | dest_bad;
                    data_cnt     <= 8'd0;
                    state        <= PAYLOAD;
                end else begin
                    case (state)
                        IDLE: begin
                            err_flags[0] <= 1'b1;
                            err_count    <= sat_inc(err_count);
                        end
                        PAYLOAD: begin
                            if (receive_is_tail) begin
                                err_flags[3] <= 1'b1;
                                pkt_done     <= 1'b1;
                                pkt_ok       <= 1'b0;
                                last_src_x   <= src_x;
                                last_src_y   <= src_y;
                                err_count    <= sat_inc(err_count);
                                state        <= IDLE;
                            end else begin
                                if (!data_ok) begin
                                    err_flags[2] <= 1'b1;
                                    bad          <= 1'b1;
                                end
                                data_cnt <= data_cnt + 8'd1;
                                if (data_cnt + 8'd1 == EXP8)
                                    state <= EXPECT_TAIL;
                            end
                        end
                        EXPECT_TAIL: begin
                            if (receive_is_tail) begin
                                if (src_mismatch)
                                    err_flags[4] <= 1'b1;
                                pkt_done   <= 1'b1;
                                pkt_ok     <= !(bad || src_mismatch);
                                last_src_x <= src_x;
                                last_src_y <= src_y;
                                if (bad || src_mismatch)
                                    err_count <= sat_inc(err_count);
                                else
                                    pkt_count <= sat_inc(pkt_count);
                                state <= IDLE;
                            end else begin
                                err_flags[3] <= 1'b1;
                                bad          <= 1'b1;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_noc_packet_sink_checker.sv
// tb/tb_noc_packet_sink_checker.sv - directed self-checking bench for noc_packet_sink_checker
`timescale 1ns/1ps
module tb_noc_packet_sink_checker;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  vld = 3'b000;
    logic [31:0] flit = '0;
    logic        hdr = 1'b0;
    logic        tl = 1'b0;

    logic [2:0]  rdy, done, ok;
    logic [3:0]  lx [3];
    logic [3:0]  ly [3];
    logic [15:0] pc [3];
    logic [15:0] ec [3];
    logic [5:0]  ef [3];

    int checks = 0;
    int errors = 0;
    logic [8:0] pulses [3][$];

    always #5 clk = ~clk;

    // 0: defaults with node (5,6); 1: two data flits; 2: stall period 4
    noc_packet_sink_checker #(.X_ID(4'd5), .Y_ID(4'd6)) u_def (
        .noc_clk(clk), .noc_rst(rst), .receive_valid(vld[0]), .receive_ready(rdy[0]),
        .receive_flit(flit), .receive_is_header(hdr), .receive_is_tail(tl),
        .pkt_done(done[0]), .pkt_ok(ok[0]), .last_src_x(lx[0]), .last_src_y(ly[0]),
        .pkt_count(pc[0]), .err_count(ec[0]), .err_flags(ef[0]));
    noc_packet_sink_checker #(.X_ID(4'd5), .Y_ID(4'd6), .EXP_DATA_FLITS(2)) u_len (
        .noc_clk(clk), .noc_rst(rst), .receive_valid(vld[1]), .receive_ready(rdy[1]),
        .receive_flit(flit), .receive_is_header(hdr), .receive_is_tail(tl),
        .pkt_done(done[1]), .pkt_ok(ok[1]), .last_src_x(lx[1]), .last_src_y(ly[1]),
        .pkt_count(pc[1]), .err_count(ec[1]), .err_flags(ef[1]));
    noc_packet_sink_checker #(.X_ID(4'd5), .Y_ID(4'd6), .STALL_PERIOD(4)) u_stall (
        .noc_clk(clk), .noc_rst(rst), .receive_valid(vld[2]), .receive_ready(rdy[2]),
        .receive_flit(flit), .receive_is_header(hdr), .receive_is_tail(tl),
        .pkt_done(done[2]), .pkt_ok(ok[2]), .last_src_x(lx[2]), .last_src_y(ly[2]),
        .pkt_count(pc[2]), .err_count(ec[2]), .err_flags(ef[2]));

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++)
            if (done[i]) pulses[i].push_back({ok[i], lx[i], ly[i]});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] hflit(input logic [3:0] sx, sy, dx, dy);
        return {sx, sy, dx, dy, 16'h0000};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        vld = 3'b000;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) pulses[i].delete();
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge, valid left high
    task automatic send(input int d, input logic h, input logic t, input logic [31:0] f);
        logic acc;
        int tries;
        flit = f; hdr = h; tl = t;
        vld[d] = 1'b1;
        tries = 0;
        acc = 1'b0;
        while (!acc && tries < 20) begin
            acc = rdy[d];
            @(posedge clk);
            @(negedge clk);
            tries++;
        end
        if (!acc) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        vld = 3'b000; hdr = 1'b0; tl = 1'b0; flit = '0;
        repeat (n) @(negedge clk);
    endtask

    task automatic clean_pkt(input int d, input logic [3:0] sx, sy);
        send(d, 1'b1, 1'b0, hflit(sx, sy, 4'd5, 4'd6));
        send(d, 1'b0, 1'b0, 32'hFFFF_FFFF);
        send(d, 1'b0, 1'b1, {sx, sy, 24'h0});
    endtask

    initial begin
        int lows;
        int okn;
        int nbefore;

        do_reset();
        check("rst_pkt_count", pc[0], 0);
        check("rst_err_count", ec[0], 0);
        check("rst_err_flags", ef[0], 0);
        check("rst_done", done[0], 0);
        check("rst_ready_nostall", rdy[0], 1);
        check("rst_ready_stall", rdy[2], 0);

        // Clean packet from (2,3)
        @(negedge clk);
        clean_pkt(0, 4'd2, 4'd3);
        idle(2);
        check("clean_pulses", pulses[0].size(), 1);
        check("clean_pulse", pulses[0][0], {1'b1, 4'd2, 4'd3});
        check("clean_pkt_count", pc[0], 1);
        check("clean_err_count", ec[0], 0);
        check("clean_err_flags", ef[0], 0);

        // Wrong destination
        do_reset();
        send(0, 1'b1, 1'b0, hflit(4'd2, 4'd3, 4'd6, 4'd6));
        send(0, 1'b0, 1'b0, 32'hFFFF_FFFF);
        send(0, 1'b0, 1'b1, {4'd2, 4'd3, 24'h0});
        idle(2);
        check("dest_pulses", pulses[0].size(), 1);
        check("dest_ok", pulses[0][0][8], 0);
        check("dest_err_flags", ef[0], 6'b000010);
        check("dest_err_count", ec[0], 1);
        check("dest_pkt_count", pc[0], 0);

        // Payload mismatch then clean packet
        do_reset();
        send(0, 1'b1, 1'b0, hflit(4'd2, 4'd3, 4'd5, 4'd6));
        send(0, 1'b0, 1'b0, 32'h0000_0000);
        send(0, 1'b0, 1'b1, {4'd2, 4'd3, 24'h0});
        idle(2);
        check("payload_err_flags", ef[0], 6'b000100);
        check("payload_err_count", ec[0], 1);
        check("payload_ok", pulses[0][0][8], 0);
        clean_pkt(0, 4'd4, 4'd7);
        idle(2);
        check("payload_then_pkt_count", pc[0], 1);
        check("payload_then_err_count", ec[0], 1);
        check("payload_then_src", pulses[0][1], {1'b1, 4'd4, 4'd7});

        // Length errors with two expected data flits
        do_reset();
        send(1, 1'b1, 1'b0, hflit(4'd2, 4'd3, 4'd5, 4'd6));
        send(1, 1'b0, 1'b0, 32'hFFFF_FFFF);
        send(1, 1'b0, 1'b1, {4'd2, 4'd3, 24'h0});
        idle(2);
        check("short_err_flags", ef[1], 6'b001000);
        check("short_err_count", ec[1], 1);
        send(1, 1'b1, 1'b0, hflit(4'd2, 4'd3, 4'd5, 4'd6));
        for (int i = 0; i < 3; i++) send(1, 1'b0, 1'b0, 32'hFFFF_FFFF);
        send(1, 1'b0, 1'b1, {4'd2, 4'd3, 24'h0});
        idle(2);
        check("long_err_count", ec[1], 2);
        check("long_pkt_count", pc[1], 0);
        check("long_pulses", pulses[1].size(), 2);
        check("long_err_flags", ef[1], 6'b001000);

        // Header mid-packet
        do_reset();
        send(0, 1'b1, 1'b0, hflit(4'd2, 4'd3, 4'd5, 4'd6));
        send(0, 1'b0, 1'b0, 32'hFFFF_FFFF);
        send(0, 1'b1, 1'b0, hflit(4'd1, 4'd1, 4'd5, 4'd6));
        send(0, 1'b0, 1'b0, 32'hFFFF_FFFF);
        send(0, 1'b0, 1'b1, {4'd1, 4'd1, 24'h0});
        idle(2);
        check("mid_pulses", pulses[0].size(), 2);
        check("mid_first", pulses[0][0], {1'b0, 4'd2, 4'd3});
        check("mid_second", pulses[0][1], {1'b1, 4'd1, 4'd1});
        check("mid_err_flags", ef[0], 6'b100000);
        check("mid_counts", {pc[0], ec[0]}, {16'd1, 16'd1});

        // Stray flit, header+tail flit, then a packet still works
        do_reset();
        send(0, 1'b0, 1'b0, 32'hFFFF_FFFF);
        send(0, 1'b1, 1'b1, hflit(4'd2, 4'd3, 4'd5, 4'd6));
        idle(2);
        check("stray_err_flags", ef[0], 6'b100001);
        check("stray_err_count", ec[0], 2);
        check("stray_pulses", pulses[0].size(), 0);
        clean_pkt(0, 4'd2, 4'd3);
        idle(2);
        check("stray_then_pkt_count", pc[0], 1);

        // Tail source mismatch
        do_reset();
        send(0, 1'b1, 1'b0, hflit(4'd2, 4'd3, 4'd5, 4'd6));
        send(0, 1'b0, 1'b0, 32'hFFFF_FFFF);
        send(0, 1'b0, 1'b1, {4'd2, 4'd4, 24'h0});
        idle(2);
        check("tailsrc_err_flags", ef[0], 6'b010000);
        check("tailsrc_counts", {pc[0], ec[0]}, {16'd0, 16'd1});

        // Backpressure pattern
        do_reset();
        lows = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!rdy[2]) lows++;
        end
        check("stall_low_cycles", lows, 10);

        // Ten packets under continuous valid
        for (int p = 0; p < 10; p++) clean_pkt(2, 4'(p), 4'd9);
        idle(2);
        okn = 0;
        foreach (pulses[2][i]) if (pulses[2][i][8]) okn++;
        check("stall_pkt_count", pc[2], 10);
        check("stall_err_count", ec[2], 0);
        check("stall_ok_pulses", okn, 10);
        check("stall_last_src", pulses[2][9], {1'b1, 4'd9, 4'd9});

        // Reset mid-packet
        send(2, 1'b1, 1'b0, hflit(4'd2, 4'd3, 4'd5, 4'd6));
        send(2, 1'b0, 1'b0, 32'hFFFF_FFFF);
        vld = 3'b000;
        nbefore = pulses[2].size();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_pkt_count", pc[2], 0);
        check("midrst_err_count", ec[2], 0);
        check("midrst_err_flags", ef[2], 0);
        idle(4);
        check("midrst_no_done", pulses[2].size(), nbefore);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
